// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 4-stage I/X/M/R core: stage valids, sequence IDs,
// load-use interlock, redirect flush, memory-busy freeze and X-stage forwarding.
module pipe_ctrl #(
  parameter int unsigned ID_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_v,
  output logic            fetch_rdy,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic            dec_use_rs1,
  input  logic            dec_use_rs2,
  input  logic [4:0]      dec_rd,
  input  logic            dec_wen,
  input  logic            dec_load,
  input  logic            x_redirect,
  input  logic            m_busy,
  output logic            stage_en,
  output logic            x_valid,
  output logic            m_valid,
  output logic            inst_v_i,
  output logic            inst_v_x,
  output logic            inst_v_m,
  output logic            inst_v_r,
  output logic [ID_W-1:0] ci,
  output logic [ID_W-1:0] cx,
  output logic [ID_W-1:0] cm,
  output logic [ID_W-1:0] cr,
  output logic            flush_v,
  output logic [ID_W-1:0] flush_id,
  output logic [1:0]      fwd_rs1_x,
  output logic [1:0]      fwd_rs2_x,
  output logic            wb_v,
  output logic [4:0]      wb_rd
);

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_R  = 2'b10
  } fwd_e;

  logic            v_x, v_m, v_r;
  logic            new_x, new_m, announced;
  logic [ID_W-1:0] next_id, id_x, id_m, id_r;
  logic [4:0]      x_rd, m_rd, r_rd;
  logic            x_wen, x_load, m_wen, r_wen;
  fwd_e            fwd1_q, fwd2_q, fwd1_d, fwd2_d;
  logic            hz, redir, issue;

  // The producer now in X will sit in M when the consumer reaches X, hence FWD_M.
  function automatic fwd_e fwd_pick(input logic [4:0] rs, input logic vx, input logic xw,
                                    input logic [4:0] xr, input logic vm, input logic mw,
                                    input logic [4:0] mr);
    fwd_e sel;
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (vx && xw && (xr == rs))      sel = FWD_M;
      else if (vm && mw && (mr == rs)) sel = FWD_R;
    end
    return sel;
  endfunction

  always_comb begin
    hz        = v_x && x_load && x_wen && (x_rd != 5'd0) &&
                ((dec_use_rs1 && (dec_rs1 == x_rd)) || (dec_use_rs2 && (dec_rs2 == x_rd)));
    redir     = v_x && x_redirect;
    fetch_rdy = !m_busy && fetch_v && (redir || !hz);
    flush_v   = !m_busy && fetch_v && redir;
    issue     = fetch_rdy && !redir;
    inst_v_i  = fetch_v && !announced;
    fwd1_d    = fwd_pick(dec_rs1, v_x, x_wen, x_rd, v_m, m_wen, m_rd);
    fwd2_d    = fwd_pick(dec_rs2, v_x, x_wen, x_rd, v_m, m_wen, m_rd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_x       <= 1'b0;
      v_m       <= 1'b0;
      v_r       <= 1'b0;
      new_x     <= 1'b0;
      new_m     <= 1'b0;
      announced <= 1'b0;
      next_id   <= '0;
      id_x      <= '0;
      id_m      <= '0;
      id_r      <= '0;
      x_rd      <= '0;
      m_rd      <= '0;
      r_rd      <= '0;
      x_wen     <= 1'b0;
      x_load    <= 1'b0;
      m_wen     <= 1'b0;
      r_wen     <= 1'b0;
      fwd1_q    <= FWD_RF;
      fwd2_q    <= FWD_RF;
    end else begin
      if (fetch_rdy)     announced <= 1'b0;
      else if (inst_v_i) announced <= 1'b1;

      if (m_busy) begin
        // Freeze X/M; R drains so a retirement never repeats, new-flags drop.
        v_r   <= 1'b0;
        new_x <= 1'b0;
        new_m <= 1'b0;
      end else begin
        v_r   <= v_m;
        id_r  <= id_m;
        r_rd  <= m_rd;
        r_wen <= m_wen;
        v_m   <= v_x;
        new_m <= v_x;
        id_m  <= id_x;
        m_rd  <= x_rd;
        m_wen <= x_wen;
        v_x   <= issue;
        new_x <= issue;
        if (fetch_rdy) next_id <= next_id + ID_W'(1);
        if (issue) begin
          id_x   <= next_id;
          x_rd   <= dec_rd;
          x_wen  <= dec_wen;
          x_load <= dec_load;
          fwd1_q <= fwd1_d;
          fwd2_q <= fwd2_d;
        end
      end
    end
  end

  assign stage_en  = !m_busy;
  assign x_valid   = v_x;
  assign m_valid   = v_m;
  assign inst_v_x  = new_x;
  assign inst_v_m  = new_m;
  assign inst_v_r  = v_r;
  assign ci        = next_id;
  assign cx        = id_x;
  assign cm        = id_m;
  assign cr        = id_r;
  assign flush_id  = next_id;
  assign fwd_rs1_x = fwd1_q;
  assign fwd_rs2_x = fwd2_q;
  assign wb_v      = v_r && r_wen && (r_rd != 5'd0);
  assign wb_rd     = r_rd;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (4-bit IDs so wrap-around is reachable):
// stimulus pushes expected events, a negedge monitor pops and compares them.
module tb_pipe_ctrl;

  localparam int unsigned IDW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           fetch_v, fetch_rdy;
  logic [4:0]     dec_rs1, dec_rs2, dec_rd;
  logic           dec_use_rs1, dec_use_rs2, dec_wen, dec_load;
  logic           x_redirect, m_busy, stage_en, x_valid, m_valid;
  logic           inst_v_i, inst_v_x, inst_v_m, inst_v_r;
  logic [IDW-1:0] ci, cx, cm, cr, flush_id;
  logic           flush_v, wb_v;
  logic [1:0]     fwd_rs1_x, fwd_rs2_x;
  logic [4:0]     wb_rd;

  pipe_ctrl #(.ID_W(IDW)) dut (
    .clk(clk), .reset(reset), .fetch_v(fetch_v), .fetch_rdy(fetch_rdy),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_wen(dec_wen), .dec_load(dec_load), .x_redirect(x_redirect),
    .m_busy(m_busy), .stage_en(stage_en), .x_valid(x_valid), .m_valid(m_valid),
    .inst_v_i(inst_v_i), .inst_v_x(inst_v_x), .inst_v_m(inst_v_m), .inst_v_r(inst_v_r),
    .ci(ci), .cx(cx), .cm(cm), .cr(cr), .flush_v(flush_v), .flush_id(flush_id),
    .fwd_rs1_x(fwd_rs1_x), .fwd_rs2_x(fwd_rs2_x), .wb_v(wb_v), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct { int id; bit fl; } con_t;
  typedef struct { int id; logic [1:0] f1; logic [1:0] f2; } iss_t;
  typedef struct { int id; bit wb; int rd; } ret_t;

  int   q_i[$];
  con_t q_c[$];
  iss_t q_x[$];
  int   q_m[$];
  ret_t q_r[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s unexpected pulse actual=1 required=0", nm);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (inst_v_i) begin
        if (q_i.size() == 0) unexp("inst_v_i");
        else chk("ci_present", ci, q_i.pop_front());
      end
      if (fetch_rdy) begin
        if (q_c.size() == 0) unexp("fetch_rdy");
        else begin
          con_t c;
          c = q_c.pop_front();
          chk("ci_consumed", ci, c.id);
          chk("flush_v", flush_v, c.fl);
          if (c.fl) chk("flush_id", flush_id, c.id);
        end
      end else if (flush_v) unexp("flush_v");
      if (inst_v_x) begin
        if (q_x.size() == 0) unexp("inst_v_x");
        else begin
          iss_t e;
          e = q_x.pop_front();
          chk("cx", cx, e.id);
          chk("fwd_rs1_x", fwd_rs1_x, e.f1);
          chk("fwd_rs2_x", fwd_rs2_x, e.f2);
        end
      end
      if (inst_v_m) begin
        if (q_m.size() == 0) unexp("inst_v_m");
        else chk("cm", cm, q_m.pop_front());
      end
      if (inst_v_r) begin
        if (q_r.size() == 0) unexp("inst_v_r");
        else begin
          ret_t r;
          r = q_r.pop_front();
          chk("cr", cr, r.id);
          chk("wb_v", wb_v, r.wb);
          if (r.wb) chk("wb_rd", wb_rd, r.rd);
        end
      end else if (wb_v) unexp("wb_v");
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (4) cyc();
  endtask

  task automatic exp_full(input int id, input logic [1:0] f1, input logic [1:0] f2,
                          input bit wb, input int rd);
    q_i.push_back(id);
    q_c.push_back('{id: id, fl: 1'b0});
    q_x.push_back('{id: id, f1: f1, f2: f2});
    q_m.push_back(id);
    q_r.push_back('{id: id, wb: wb, rd: rd});
  endtask

  // Holds the instruction until consumed; waits = cycles with fetch_rdy low.
  task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic wen,
                         input logic ld, output int waits);
    dec_rs1 = rs1; dec_rs2 = rs2; dec_use_rs1 = u1; dec_use_rs2 = u2;
    dec_rd = rd; dec_wen = wen; dec_load = ld; fetch_v = 1'b1;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (fetch_rdy) break;
      waits++;
      if (waits > 20) begin
        unexp("fetch_rdy_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    fetch_v = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int w;
    reset = 1'b1; fetch_v = 1'b0; x_redirect = 1'b0; m_busy = 1'b0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_wen = 1'b0; dec_load = 1'b0;
    repeat (2) cyc();
    chk("rst_x_valid", x_valid, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_inst_v_r", inst_v_r, 0);
    chk("rst_ci", ci, 0);
    chk("rst_fwd1", fwd_rs1_x, 0);
    chk("rst_stage_en", stage_en, 1);
    m_busy = 1'b1;
    #1;
    chk("rst_stage_en_busy", stage_en, 0);
    m_busy = 1'b0;
    reset = 1'b0;
    cyc();

    // Three independent ALU ops: IDs 0..2, no forwarding.
    exp_full(0, 2'b00, 2'b00, 1, 1); present(10, 11, 1, 1, 1, 1, 0, w);
    exp_full(1, 2'b00, 2'b00, 1, 2); present(10, 11, 1, 1, 2, 1, 0, w);
    exp_full(2, 2'b00, 2'b00, 1, 3); present(10, 11, 1, 1, 3, 1, 0, w);
    chk("no_stall", w, 0);
    @(negedge clk);
    chk("ret_timing_v", inst_v_r, 1);
    chk("ret_timing_id", cr, 0);
    chk("x_valid_full", x_valid, 1);
    chk("m_valid_full", m_valid, 1);
    drain();

    // Back-to-back dependency -> M forward; one gap instruction -> R forward.
    exp_full(3, 2'b00, 2'b00, 1, 5); present(0, 0, 1, 0, 5, 1, 0, w);
    exp_full(4, 2'b01, 2'b01, 1, 6); present(5, 5, 1, 1, 6, 1, 0, w);
    exp_full(5, 2'b00, 2'b00, 1, 5); present(0, 0, 1, 0, 5, 1, 0, w);
    exp_full(6, 2'b00, 2'b00, 1, 9); present(12, 13, 1, 1, 9, 1, 0, w);
    exp_full(7, 2'b10, 2'b10, 1, 6); present(5, 5, 1, 1, 6, 1, 0, w);
    drain();

    // Load-use: one stall cycle, then R-result forward on rs1.
    exp_full(8, 2'b00, 2'b00, 1, 7); present(1, 0, 1, 0, 7, 1, 1, w);
    exp_full(9, 2'b10, 2'b00, 1, 8); present(7, 0, 1, 1, 8, 1, 0, w);
    chk("loaduse_stall", w, 1);
    drain();

    // Taken branch in X squashes the I-stage instruction; its ID is consumed.
    exp_full(10, 2'b00, 2'b00, 0, 0); present(3, 4, 1, 1, 0, 0, 0, w);
    x_redirect = 1'b1;
    q_i.push_back(11);
    q_c.push_back('{id: 11, fl: 1'b1});
    present(1, 2, 1, 1, 12, 1, 0, w);
    chk("flush_wait", w, 0);
    x_redirect = 1'b0;
    exp_full(12, 2'b00, 2'b00, 1, 3); present(3, 4, 1, 1, 3, 1, 0, w);
    drain();

    // Memory busy for three cycles with X and M occupied.
    exp_full(13, 2'b00, 2'b00, 1, 1); present(10, 11, 1, 1, 1, 1, 0, w);
    exp_full(14, 2'b00, 2'b00, 1, 2); present(10, 11, 1, 1, 2, 1, 0, w);
    exp_full(15, 2'b00, 2'b00, 1, 3);
    fork
      begin
        m_busy = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("busy_stage_en", stage_en, 0);
          chk("busy_inst_v_r", inst_v_r, 0);
          @(posedge clk);
          #1;
        end
        m_busy = 1'b0;
      end
      present(10, 11, 1, 1, 3, 1, 0, w);
    join
    chk("busy_wait", w, 3);
    drain();

    // ID wrap: the 17th instruction gets ID 0; then reset with X/M/R full.
    q_i.push_back(0); q_c.push_back('{id: 0, fl: 1'b0});
    q_x.push_back('{id: 0, f1: 2'b00, f2: 2'b00}); q_m.push_back(0);
    present(10, 11, 1, 1, 1, 1, 0, w);
    q_i.push_back(1); q_c.push_back('{id: 1, fl: 1'b0});
    q_x.push_back('{id: 1, f1: 2'b00, f2: 2'b00});
    present(10, 11, 1, 1, 2, 1, 0, w);
    q_i.push_back(2); q_c.push_back('{id: 2, fl: 1'b0});
    present(10, 11, 1, 1, 3, 1, 0, w);
    reset = 1'b1;
    #1;
    chk("midrst_x_valid", x_valid, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_inst_v_r", inst_v_r, 0);
    chk("midrst_inst_v_x", inst_v_x, 0);
    chk("midrst_ci", ci, 0);
    cyc();
    reset = 1'b0;
    exp_full(0, 2'b00, 2'b00, 1, 4); present(10, 11, 1, 1, 4, 1, 0, w);
    drain();

    chk("q_i_empty", q_i.size(), 0);
    chk("q_c_empty", q_c.size(), 0);
    chk("q_x_empty", q_x.size(), 0);
    chk("q_m_empty", q_m.size(), 0);
    chk("q_r_empty", q_r.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
